// File: rtl/seg7_frame_decoder.sv
// Monitors a multiplexed 4-digit 7-segment bus. It filters glitches, decodes each digit and
// publishes every completed 16-bit frame with change, stale and error flags.
module seg7_frame_decoder #(
  parameter int unsigned HOLD_CYCLES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] HEX,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        value_changed,
  output logic        stale,
  output logic        code_err,
  output logic        sel_err
);

  // The hold counter saturates one past the target, so each run is accepted exactly once.
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 2);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldTarget = HoldW'(HOLD_CYCLES);
  localparam logic [HoldW-1:0] HoldMax    = HoldW'(HOLD_CYCLES + 1);
  localparam logic [TmoW-1:0]  TmoMax     = TmoW'(TIMEOUT_CYCLES);
  localparam logic [11:0]      HexIdle    = 12'h9A0;

  typedef enum logic [0:0] {StCollect, StPublish} state_e;

  state_e            state_q, state_d;
  logic [11:0]       hex_q, hex_prev_q;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [15:0]       slots_q, slots_d;
  logic [3:0]        mask_q, mask_d;
  logic [15:0]       value_q, value_d;
  logic              changed_q, changed_d;
  logic              first_q, first_d;
  logic              code_err_q, code_err_d;
  logic              sel_err_q, sel_err_d;

  logic              accept;
  logic [3:0]        sel;
  logic              sel_none, sel_one, sel_multi;
  logic [1:0]        slot_idx;
  logic [7:0]        seg;
  logic [3:0]        nib;
  logic              code_ok;
  logic              publish_start;

  // Glitch filter: a pattern must sit on the bus for HOLD_CYCLES registered samples.
  always_comb begin
    if (hex_q != hex_prev_q) begin
      hold_d = HoldW'(1);
    end else if (hold_q == HoldMax) begin
      hold_d = hold_q;
    end else begin
      hold_d = hold_q + HoldW'(1);
    end
  end

  assign accept = (hold_d == HoldTarget);

  // sel[3] is D1 (value[15:12]) down to sel[0] for D4 (value[3:0]).
  assign sel       = {~hex_q[11], ~hex_q[8], ~hex_q[7], ~hex_q[5]};
  assign sel_none  = (sel == 4'd0);
  assign sel_one   = !sel_none && ((sel & (sel - 4'd1)) == 4'd0);
  assign sel_multi = !sel_none && !sel_one;

  always_comb begin
    slot_idx = 2'd0;
    unique case (sel)
      4'b1000: slot_idx = 2'd3;
      4'b0100: slot_idx = 2'd2;
      4'b0010: slot_idx = 2'd1;
      4'b0001: slot_idx = 2'd0;
      default: slot_idx = 2'd0;
    endcase
  end

  assign seg = {hex_q[10], hex_q[9], hex_q[6], hex_q[4], hex_q[3], hex_q[2], hex_q[1], hex_q[0]};

  always_comb begin
    nib     = 4'h0;
    code_ok = 1'b1;
    case (seg)
      8'hEB: nib = 4'h0;
      8'h28: nib = 4'h1;
      8'hB3: nib = 4'h2;
      8'hBA: nib = 4'h3;
      8'h78: nib = 4'h4;
      8'hDA: nib = 4'h5;
      8'hDB: nib = 4'h6;
      8'hA8: nib = 4'h7;
      8'hFB: nib = 4'h8;
      8'hFA: nib = 4'h9;
      8'hF9: nib = 4'hA;
      8'h5B: nib = 4'hB;
      8'hC3: nib = 4'hC;
      8'h3B: nib = 4'hD;
      8'hD3: nib = 4'hE;
      8'hD1: nib = 4'hF;
      default: code_ok = 1'b0;
    endcase
  end

  assign publish_start = (state_q == StCollect) && (mask_q == 4'hF);

  // The mask clear happens first so a digit captured on the publish edge opens the next frame.
  always_comb begin
    slots_d    = slots_q;
    mask_d     = mask_q;
    code_err_d = 1'b0;
    sel_err_d  = 1'b0;
    if (publish_start) begin
      mask_d = 4'd0;
    end
    if (accept) begin
      if (sel_multi) begin
        sel_err_d = 1'b1;
      end else if (sel_one) begin
        if (code_ok) begin
          slots_d[{slot_idx, 2'b00} +: 4] = nib;
          mask_d[slot_idx]                = 1'b1;
        end else begin
          mask_d[slot_idx] = 1'b0;
          code_err_d       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    value_d   = value_q;
    changed_d = changed_q;
    first_d   = first_q;
    if (publish_start) begin
      value_d   = slots_q;
      changed_d = first_q || (slots_q != value_q);
      first_d   = 1'b0;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (mask_q == 4'hF) state_d = StPublish;
      StPublish: state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  // Held at zero from the publish edge through the publish cycle, so stale drops with value_valid.
  always_comb begin
    if ((state_d == StPublish) || (state_q == StPublish)) begin
      tmo_d = '0;
    end else if (tmo_q == TmoMax) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  // FSM state register and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StCollect;
      hex_q      <= HexIdle;
      hex_prev_q <= HexIdle;
      hold_q     <= '0;
      tmo_q      <= '0;
      slots_q    <= 16'd0;
      mask_q     <= 4'd0;
      value_q    <= 16'd0;
      changed_q  <= 1'b0;
      first_q    <= 1'b1;
      code_err_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hex_q      <= HEX;
      hex_prev_q <= hex_q;
      hold_q     <= hold_d;
      tmo_q      <= tmo_d;
      slots_q    <= slots_d;
      mask_q     <= mask_d;
      value_q    <= value_d;
      changed_q  <= changed_d;
      first_q    <= first_d;
      code_err_q <= code_err_d;
      sel_err_q  <= sel_err_d;
    end
  end

  // FSM outputs
  always_comb begin
    value         = value_q;
    value_valid   = (state_q == StPublish);
    value_changed = (state_q == StPublish) && changed_q;
    stale         = (tmo_q == TmoMax);
    code_err      = code_err_q;
    sel_err       = sel_err_q;
  end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder: one instance with HOLD_CYCLES=1 and one with
// HOLD_CYCLES=3 share the same bus and reset.
module tb_seg7_frame_decoder;

  localparam logic [11:0] Blank = 12'h9A0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] hex_bus = 12'h9A0;

  logic [15:0] value1, value3;
  logic        vv1, vc1, stale1, ce1, se1;
  logic        vv3, vc3, stale3, ce3, se3;

  int checks = 0;
  int errors = 0;
  int n_vv1 = 0, n_vc1 = 0, n_ce1 = 0, n_se1 = 0;
  int n_vv3 = 0, n_vc3 = 0, n_ce3 = 0, n_se3 = 0;
  int s_vv1, s_vc1, s_ce1, s_se1, s_vv3, s_vc3, s_ce3, s_se3;

  logic [7:0] seg_tab [16] = '{8'hEB, 8'h28, 8'hB3, 8'hBA, 8'h78, 8'hDA, 8'hDB, 8'hA8,
                               8'hFB, 8'hFA, 8'hF9, 8'h5B, 8'hC3, 8'h3B, 8'hD3, 8'hD1};

  seg7_frame_decoder #(.HOLD_CYCLES(1), .TIMEOUT_CYCLES(1024)) dut1 (
    .clk(clk), .rst_n(rst_n), .HEX(hex_bus), .value(value1), .value_valid(vv1),
    .value_changed(vc1), .stale(stale1), .code_err(ce1), .sel_err(se1)
  );

  seg7_frame_decoder #(.HOLD_CYCLES(3), .TIMEOUT_CYCLES(1024)) dut3 (
    .clk(clk), .rst_n(rst_n), .HEX(hex_bus), .value(value3), .value_valid(vv3),
    .value_changed(vc3), .stale(stale3), .code_err(ce3), .sel_err(se3)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vv1 === 1'b1) n_vv1++;
    if (vc1 === 1'b1) n_vc1++;
    if (ce1 === 1'b1) n_ce1++;
    if (se1 === 1'b1) n_se1++;
    if (vv3 === 1'b1) n_vv3++;
    if (vc3 === 1'b1) n_vc3++;
    if (ce3 === 1'b1) n_ce3++;
    if (se3 === 1'b1) n_se3++;
  end

  // Digit d: 1..4 = D1..D4
  function automatic logic [11:0] enc(input int d, input logic [7:0] s);
    logic [11:0] h;
    h      = 12'h9A0;
    h[10]  = s[7];
    h[9]   = s[6];
    h[6]   = s[5];
    h[4:0] = s[4:0];
    case (d)
      1:       h[11] = 1'b0;
      2:       h[8]  = 1'b0;
      3:       h[7]  = 1'b0;
      default: h[5]  = 1'b0;
    endcase
    return h;
  endfunction

  function automatic logic [11:0] dig(input int d, input logic [3:0] n);
    return enc(d, seg_tab[n]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [11:0] h, input int n);
    repeat (n) begin
      @(negedge clk);
      hex_bus = h;
    end
  endtask

  task automatic send_frame(input logic [15:0] v);
    put(dig(4, v[3:0]), 1);
    put(dig(3, v[7:4]), 1);
    put(dig(2, v[11:8]), 1);
    put(dig(1, v[15:12]), 1);
    put(Blank, 1);
  endtask

  task automatic wait_vv(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (vv1 === 1'b1) found = 1'b1;
    end
    chk(tag, found, 1);
  endtask

  task automatic snap();
    s_vv1 = n_vv1; s_vc1 = n_vc1; s_ce1 = n_ce1; s_se1 = n_se1;
    s_vv3 = n_vv3; s_vc3 = n_vc3; s_ce3 = n_ce3; s_se3 = n_se3;
  endtask

  initial begin
    logic [11:0] rot [4];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_value", value1, 16'h0);
    chk("rst_valid", vv1, 0);
    chk("rst_changed", vc1, 0);
    chk("rst_stale", stale1, 0);
    chk("rst_code_err", ce1, 0);
    chk("rst_sel_err", se1, 0);
    chk("rst_value3", value3, 16'h0);
    rst_n = 1'b1;

    // 1: continuous rotation of 16'h1A2F, HOLD=1
    rot[0] = dig(4, 4'hF);
    rot[1] = dig(3, 4'h2);
    rot[2] = dig(2, 4'hA);
    rot[3] = dig(1, 4'h1);
    snap();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 6) begin
        chk("t1_first_valid", vv1, 1);
        chk("t1_first_changed", vc1, 1);
        chk("t1_first_value", value1, 16'h1A2F);
      end
      if (k == 7) chk("t1_valid_one_cycle", vv1, 0);
      if (k == 10) begin
        chk("t1_second_valid", vv1, 1);
        chk("t1_second_unchanged", vc1, 0);
      end
      hex_bus = rot[k % 4];
    end
    put(Blank, 6);
    chk("t1_publish_count", n_vv1 - s_vv1, 3);
    chk("t1_changed_count", n_vc1 - s_vc1, 1);
    chk("t1_hold3_no_publish", n_vv3 - s_vv3, 0);

    // 2: HOLD=3 with a 1-cycle D4 glitch between digits
    snap();
    put(dig(4, 4'hF), 3);
    put(dig(4, 4'h0), 1);
    put(dig(3, 4'h2), 3);
    put(dig(2, 4'hA), 3);
    put(dig(1, 4'h1), 3);
    put(Blank, 8);
    chk("t2_hold3_value", value3, 16'h1A2F);
    chk("t2_hold3_publish", n_vv3 - s_vv3, 1);
    chk("t2_hold3_changed", n_vc3 - s_vc3, 1);
    chk("t2_hold1_latest_wins", value1, 16'h1A20);
    chk("t2_hold1_publish", n_vv1 - s_vv1, 1);

    // 3: bad D3 code, then a valid D3 completes 16'h8E35
    snap();
    put(dig(4, 4'h5), 1);
    put(enc(3, 8'h00), 1);
    put(dig(2, 4'hE), 1);
    put(dig(1, 4'h8), 1);
    put(Blank, 6);
    chk("t3_code_err", n_ce1 - s_ce1, 1);
    chk("t3_no_publish", n_vv1 - s_vv1, 0);
    put(dig(3, 4'h3), 1);
    put(Blank, 6);
    chk("t3_publish", n_vv1 - s_vv1, 1);
    chk("t3_value", value1, 16'h8E35);
    chk("t3_hold3_no_code_err", n_ce3 - s_ce3, 0);

    // 4: all enables low mid-frame, then stale timing
    snap();
    put(dig(4, 4'h6), 1);
    put(dig(3, 4'h9), 1);
    put(12'h000, 1);
    put(dig(2, 4'hF), 1);
    put(dig(1, 4'h0), 1);
    put(Blank, 1);
    wait_vv("t4_publish");
    chk("t4_value", value1, 16'h0F96);
    chk("t4_stale_clear", stale1, 0);
    chk("t4_sel_err", n_se1 - s_se1, 1);
    chk("t4_hold3_no_sel_err", n_se3 - s_se3, 0);
    repeat (1024) @(negedge clk);
    chk("t4_not_yet_stale", stale1, 0);
    @(negedge clk);
    chk("t4_stale", stale1, 1);
    chk("t4_hold3_stale", stale3, 1);

    // 6: 1234, 1234, BEEF
    send_frame(16'h1234);
    wait_vv("t6_pub1");
    chk("t6_value1", value1, 16'h1234);
    chk("t6_changed1", vc1, 1);
    chk("t6_stale_cleared", stale1, 0);
    send_frame(16'h1234);
    wait_vv("t6_pub2");
    chk("t6_changed2", vc1, 0);
    send_frame(16'hBEEF);
    wait_vv("t6_pub3");
    chk("t6_value3", value1, 16'hBEEF);
    chk("t6_changed3", vc1, 1);

    // 5: reset after D4 and D3 of 16'hABCD are captured
    put(dig(4, 4'hD), 1);
    put(dig(3, 4'hC), 1);
    put(Blank, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_value", value1, 16'h0);
    chk("t5_rst_valid", vv1, 0);
    chk("t5_rst_stale", stale1, 0);
    chk("t5_rst_value3", value3, 16'h0);
    rst_n = 1'b1;
    snap();
    put(dig(2, 4'hB), 1);
    put(dig(1, 4'hA), 1);
    put(Blank, 6);
    chk("t5_partial_no_publish", n_vv1 - s_vv1, 0);
    put(dig(4, 4'hD), 1);
    put(dig(3, 4'hC), 1);
    put(Blank, 1);
    wait_vv("t5_publish");
    chk("t5_value", value1, 16'hABCD);
    chk("t5_changed", vc1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
